alu_sweep_gen: RTL and testbench
================================

Name: alu_sweep_gen

Overview:
Synthesizable operand/opcode sweep generator that sits directly upstream of the ALU and drives its data_a, data_b, flags_in and operation inputs. On a start request it steps through an exhaustive operand sweep. Each vector is held for a fixed number of cycles, then the generator idles through a drain window and reports completion. It replaces hand-written stimulus loops so the ALU can be exercised on-chip or in emulation.

Parameters:
DATA_W, 8, operand width (data_a, data_b)
FLAGS_W, 4, flags_in width
OP_W, 3, operation width
HOLD_CYCLES, 10, cycles each vector is held (>=1)
DRAIN_CYCLES, 1000, cycles after last vector before done (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  cancel sweep; return to IDLE, no done
mode  in  2  sweep_mode_e: 00 B_ONLY, 01 A_B_NESTED, 10 OP_B_NESTED, 11 reserved (=B_ONLY)
a_init  in  DATA_W  starting data_a
flags_init  in  FLAGS_W  flags_in value for the whole sweep
op_init  in  OP_W  operation for B_ONLY/A_B_NESTED
data_a  out  DATA_W  ALU operand A
data_b  out  DATA_W  ALU operand B
flags_in  out  FLAGS_W  ALU flags input
operation  out  OP_W  ALU opcode
step_valid  out  1  1-cycle pulse in the first cycle a new vector is presented
busy  out  1  high in HOLD and DRAIN
done  out  1  1-cycle pulse at sweep completion

Behaviour:
- Reset: state IDLE; data_a, data_b, flags_in, operation, step_valid, busy, done all 0; counters 0.
- FSM states: IDLE -> HOLD -> DRAIN -> DONE -> IDLE.
- IDLE with start=1 at edge k loads the vector registers:
  - data_a=a_init, data_b=0, flags_in=flags_init.
  - operation=op_init, or 0 in OP_B_NESTED.
  - Enters HOLD with busy=1 and step_valid=1 in the cycle after edge k.
- HOLD: hold counter counts 0..HOLD_CYCLES-1. Each vector is visible for exactly HOLD_CYCLES cycles.
- When the counter expires and the vector is not last:
  - Advance data_b by 1 (mod 2^DATA_W).
  - On data_b wrap 255->0: A_B_NESTED increments data_a (mod 2^DATA_W); OP_B_NESTED increments operation.
  - step_valid pulses for the new vector.
- Last vector, per mode:
  - B_ONLY: data_b=255.
  - A_B_NESTED: data_b=255 and data_a=a_init-1 (mod 256), i.e. 65536 vectors.
  - OP_B_NESTED: data_b=255 and operation=2^OP_W-1, i.e. 2048 vectors.
- Last vector expiry -> DRAIN. Outputs hold the last vector. The drain counter runs DRAIN_CYCLES cycles.
- DRAIN expiry -> DONE for one cycle: done=1, busy=0. Then IDLE. Outputs keep the last vector until the next start or reset.
- Total length, start edge to done: N*HOLD_CYCLES + DRAIN_CYCLES cycles. Default B_ONLY: 256*10+1000 = 3560.
- start while not IDLE: ignored. mode and inits are sampled only at start.
- abort in any non-IDLE state: next edge goes to IDLE with all outputs 0 and no done.
- abort and start in the same IDLE cycle: abort wins, no sweep starts.
- Reset mid-sweep: identical to power-on reset.
- Counters sized $clog2(max(HOLD_CYCLES,DRAIN_CYCLES)+1). There is no overflow past the terminal count.

Decomposition:
- Package alu_pkg holds:
  - DATA_W, FLAGS_W, OP_W constants.
  - sweep_mode_e enum.
  - sweep_state_e enum (IDLE, HOLD, DRAIN, DONE).
- One sub-module, sweep_timer: loadable terminal-count counter with load, enable and expire pulse. It is instantiated twice, for hold and drain, or once with a muxed terminal value.

Test Plan:
- B_ONLY, HOLD=2, DRAIN=3, a_init=0x12, op_init=3, flags_init=0xA. Start -> data_b steps 0..255, 2 cycles each; data_a=0x12, operation=3, flags_in=0xA constant; 256 step_valid pulses; done exactly 515 cycles after the start edge.
- A_B_NESTED, HOLD=1, a_init=0xFE -> after data_b 255, data_a goes 0xFF, then 0x00 (wrap); last vector a=0xFD, b=0xFF; 65536 step_valid pulses.
- OP_B_NESTED, HOLD=1, DRAIN=1 -> operation goes 0..7, advancing at each data_b wrap; done after 2049 cycles; busy low on the done cycle.
- Abort at vector data_b=0x40 mid-HOLD -> next cycle all outputs 0, busy=0, done never asserted; a later start begins again from data_b=0.
- start held high during a sweep, plus start and abort together in IDLE -> no restart or glitch in data_b; simultaneous case stays IDLE.
- Reset asserted during DRAIN -> outputs 0, state IDLE, no done pulse; a subsequent start behaves identically to the first test.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, enums and vector payload for the ALU operand sweep generator.
package alu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [1:0] {
    B_ONLY      = 2'b00,
    A_B_NESTED  = 2'b01,
    OP_B_NESTED = 2'b10,
    MODE_RSVD   = 2'b11
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } sweep_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data_a;
    logic [DATA_W-1:0]  data_b;
    logic [FLAGS_W-1:0] flags;
    logic [OP_W-1:0]    op;
  } sweep_vec_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable terminal-count counter: counts 0..term-1 while enabled, pulses expire_c on the last count.
module sweep_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_c = en && (cnt_q == (term - CNT_W'(1)));

  // Wraps to zero on expiry, so the count never runs past the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire_c ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_sweep_gen.sv
// Exhaustive ALU operand/opcode sweep generator: holds each vector HOLD_CYCLES,
// then drains DRAIN_CYCLES before pulsing done.
module alu_sweep_gen
  import alu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 10,
  parameter int unsigned DRAIN_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  a_init,
  input  logic [FLAGS_W-1:0] flags_init,
  input  logic [OP_W-1:0]    op_init,
  output logic [DATA_W-1:0]  data_a,
  output logic [DATA_W-1:0]  data_b,
  output logic [FLAGS_W-1:0] flags_in,
  output logic [OP_W-1:0]    operation,
  output logic               step_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, DRAIN_CYCLES) + 1);

  sweep_state_e      state_q, state_d;
  sweep_mode_e       mode_q, mode_d;
  sweep_mode_e       mode_in_c;
  logic [DATA_W-1:0] a_init_q, a_init_d;
  sweep_vec_t        vec_q, vec_d;
  logic              step_valid_q, step_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hold_exp_c;
  logic              drain_exp_c;
  logic              last_c;

  assign mode_in_c = sweep_mode_e'(mode);

  sweep_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (state_q == IDLE),
    .en       (state_q == HOLD),
    .term     (CNT_W'(HOLD_CYCLES)),
    .expire_c (hold_exp_c)
  );

  sweep_timer #(.CNT_W(CNT_W)) u_drain_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (state_q == IDLE),
    .en       (state_q == DRAIN),
    .term     (CNT_W'(DRAIN_CYCLES)),
    .expire_c (drain_exp_c)
  );

  // Last vector: data_b at max plus the outer loop at its final value.
  always_comb begin
    last_c = (vec_q.data_b == '1);
    case (mode_q)
      A_B_NESTED:  last_c = last_c && (vec_q.data_a == (a_init_q - DATA_W'(1)));
      OP_B_NESTED: last_c = last_c && (vec_q.op == '1);
      default:     last_c = last_c;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    a_init_d     = a_init_q;
    vec_d        = vec_q;
    step_valid_d = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = HOLD;
          step_valid_d = 1'b1;
          mode_d       = (mode_in_c == MODE_RSVD) ? B_ONLY : mode_in_c;
          a_init_d     = a_init;
          vec_d.data_a = a_init;
          vec_d.data_b = '0;
          vec_d.flags  = flags_init;
          vec_d.op     = (mode_d == OP_B_NESTED) ? '0 : op_init;
        end
      end
      HOLD: begin
        if (hold_exp_c) begin
          if (last_c) begin
            state_d = DRAIN;
          end else begin
            vec_d.data_b = vec_q.data_b + DATA_W'(1);
            step_valid_d = 1'b1;
            if (vec_q.data_b == '1) begin
              if (mode_q == A_B_NESTED)       vec_d.data_a = vec_q.data_a + DATA_W'(1);
              else if (mode_q == OP_B_NESTED) vec_d.op     = vec_q.op + OP_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (drain_exp_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort from any active state clears the vector and suppresses done.
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      vec_d        = '0;
      step_valid_d = 1'b0;
      done_d       = 1'b0;
    end

    busy_d = (state_d == HOLD) || (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= B_ONLY;
      a_init_q     <= '0;
      vec_q        <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      a_init_q     <= a_init_d;
      vec_q        <= vec_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_a     = vec_q.data_a;
  assign data_b     = vec_q.data_b;
  assign flags_in   = vec_q.flags;
  assign operation  = vec_q.op;
  assign step_valid = step_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_sweep_gen.sv
// Bench for alu_sweep_gen: two instances (HOLD=2/DRAIN=3 and HOLD=1/DRAIN=1) checked against a vector scoreboard.
module tb_alu_sweep_gen;
  import alu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic [1:0]         mode;
  logic [DATA_W-1:0]  a_init;
  logic [FLAGS_W-1:0] flags_init;
  logic [OP_W-1:0]    op_init;
  logic               start0, abort0, start1, abort1;

  logic [DATA_W-1:0]  a0, b0, a1, b1;
  logic [FLAGS_W-1:0] f0, f1;
  logic [OP_W-1:0]    o0, o1;
  logic               sv0, busy0, done0, sv1, busy1, done1;

  alu_sweep_gen #(.HOLD_CYCLES(2), .DRAIN_CYCLES(3)) u0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0), .mode(mode),
    .a_init(a_init), .flags_init(flags_init), .op_init(op_init),
    .data_a(a0), .data_b(b0), .flags_in(f0), .operation(o0),
    .step_valid(sv0), .busy(busy0), .done(done0)
  );

  alu_sweep_gen #(.HOLD_CYCLES(1), .DRAIN_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .mode(mode),
    .a_init(a_init), .flags_init(flags_init), .op_init(op_init),
    .data_a(a1), .data_b(b1), .flags_in(f1), .operation(o1),
    .step_valid(sv1), .busy(busy1), .done(done1)
  );

  int         total = 0;
  int         bad   = 0;
  sweep_vec_t q0[$];
  sweep_vec_t q1[$];
  sweep_vec_t e0, e1;
  int         sv_cnt0 = 0, sv_cnt1 = 0, gap0 = 0, gap1 = 0;
  bit         prev0 = 1'b0, prev1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumers: pop one expected vector per step_valid and check the hold spacing.
  always @(negedge clock) begin
    if (sv0) begin
      sv_cnt0++;
      if (prev0) check("gap0", 64'(gap0), 64'd2);
      prev0 = 1'b1;
      gap0  = 1;
      if (q0.size() == 0) check("extra_step0", 64'd1, 64'd0);
      else begin
        e0 = q0.pop_front();
        check("vec0", 64'({a0, b0, f0, o0}), 64'(e0));
      end
    end else if (busy0) gap0++;
  end

  always @(negedge clock) begin
    if (sv1) begin
      sv_cnt1++;
      if (prev1) check("gap1", 64'(gap1), 64'd1);
      prev1 = 1'b1;
      gap1  = 1;
      if (q1.size() == 0) check("extra_step1", 64'd1, 64'd0);
      else begin
        e1 = q1.pop_front();
        check("vec1", 64'({a1, b1, f1, o1}), 64'(e1));
      end
    end else if (busy1) gap1++;
  end

  // Reference model of the sweep order.
  task automatic push_sweep(input int inst, input logic [1:0] m, input logic [7:0] a,
                            input logic [2:0] op, input logic [3:0] fl);
    sweep_vec_t v;
    int outer;
    outer = (m == 2'b01) ? 256 : (m == 2'b10) ? 8 : 1;
    for (int i = 0; i < outer; i++) begin
      for (int b = 0; b < 256; b++) begin
        v.data_a = (m == 2'b01) ? DATA_W'(int'(a) + i) : a;
        v.data_b = DATA_W'(b);
        v.flags  = fl;
        v.op     = (m == 2'b10) ? OP_W'(i) : op;
        if (inst == 0) q0.push_back(v);
        else           q1.push_back(v);
      end
    end
  endtask

  task automatic start_sweep(input int inst, input logic [1:0] m, input logic [7:0] a,
                             input logic [2:0] op, input logic [3:0] fl, input bit hold_start);
    mode = m; a_init = a; op_init = op; flags_init = fl;
    if (inst == 0) begin sv_cnt0 = 0; prev0 = 1'b0; end
    else           begin sv_cnt1 = 0; prev1 = 1'b0; end
    push_sweep(inst, m, a, op, fl);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    if (!hold_start) begin start0 = 1'b0; start1 = 1'b0; end
  endtask

  task automatic wait_done(input int inst, input int exp_cycles, input int exp_steps);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < exp_cycles + 50) begin
      @(posedge clock); #1;
      n++;
      got = (inst == 0) ? done0 : done1;
    end
    start0 = 1'b0; start1 = 1'b0;
    check("done_latency", 64'(n), 64'(exp_cycles));
    check("busy_on_done", 64'((inst == 0) ? busy0 : busy1), 64'd0);
    check("queue_drained", 64'((inst == 0) ? q0.size() : q1.size()), 64'd0);
    check("step_count", 64'((inst == 0) ? sv_cnt0 : sv_cnt1), 64'(exp_steps));
    @(posedge clock); #1;
    check("done_one_cycle", 64'((inst == 0) ? done0 : done1), 64'd0);
  endtask

  initial begin
    bit found;
    bit seen;
    reset = 1'b1; mode = 2'b00; a_init = '0; flags_init = '0; op_init = '0;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_out0", 64'({a0, b0, f0, o0, sv0, busy0, done0}), 64'd0);
    check("reset_out1", 64'({a1, b1, f1, o1, sv1, busy1, done1}), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_out0", 64'({a0, b0, f0, o0, sv0, busy0, done0}), 64'd0);

    // B_ONLY, HOLD=2, DRAIN=3
    start_sweep(0, 2'b00, 8'h12, 3'd3, 4'hA, 1'b0);
    check("busy_after_start", 64'(busy0), 64'd1);
    wait_done(0, 515, 256);
    check("b_only_last", 64'({a0, b0, f0, o0}), 64'({8'h12, 8'hFF, 4'hA, 3'd3}));

    // A_B_NESTED, HOLD=1, a_init wraps through 0xFF -> 0x00
    start_sweep(1, 2'b01, 8'hFE, 3'd5, 4'h3, 1'b0);
    wait_done(1, 65537, 65536);
    check("ab_last", 64'({a1, b1, f1, o1}), 64'({8'hFD, 8'hFF, 4'h3, 3'd5}));

    // OP_B_NESTED, HOLD=1, DRAIN=1; op_init ignored
    start_sweep(1, 2'b10, 8'h33, 3'd5, 4'hC, 1'b0);
    wait_done(1, 2049, 2048);
    check("opb_last", 64'({a1, b1, f1, o1}), 64'({8'h33, 8'hFF, 4'hC, 3'd7}));

    // Abort mid-HOLD at data_b=0x40
    start_sweep(0, 2'b00, 8'h55, 3'd1, 4'h6, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clock); #1;
      found = sv0 && (b0 == 8'h40);
    end
    check("reach_0x40", 64'(found), 64'd1);
    @(posedge clock); #1;
    abort0 = 1'b1;
    @(posedge clock); #1;
    abort0 = 1'b0;
    check("abort_out", 64'({a0, b0, f0, o0, sv0, busy0, done0}), 64'd0);
    q0.delete();
    seen = 1'b0;
    repeat (10) begin @(posedge clock); #1; seen |= done0 | busy0; end
    check("abort_no_done", 64'(seen), 64'd0);

    // Restart with start held high through the whole sweep
    start_sweep(0, 2'b00, 8'h55, 3'd1, 4'h6, 1'b1);
    wait_done(0, 515, 256);

    // start and abort together in IDLE: abort wins
    start0 = 1'b1; abort0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; abort0 = 1'b0;
    seen = 1'b0;
    repeat (3) begin seen |= busy0 | sv0 | done0; @(posedge clock); #1; end
    check("start_abort_idle", 64'(seen), 64'd0);

    // Reset during DRAIN, then a clean rerun of the first sweep
    start_sweep(0, 2'b00, 8'h12, 3'd3, 4'hA, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clock); #1;
      found = sv0 && (b0 == 8'hFF);
    end
    check("reach_last", 64'(found), 64'd1);
    repeat (2) @(posedge clock);
    #1;
    check("in_drain", 64'({busy0, sv0, done0}), 64'b100);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("reset_drain_out", 64'({a0, b0, f0, o0, sv0, busy0, done0}), 64'd0);
    seen = 1'b0;
    repeat (10) begin @(posedge clock); #1; seen |= done0 | busy0; end
    check("reset_no_done", 64'(seen), 64'd0);
    start_sweep(0, 2'b00, 8'h12, 3'd3, 4'hA, 1'b0);
    wait_done(0, 515, 256);
    check("rerun_last", 64'({a0, b0, f0, o0}), 64'({8'h12, 8'hFF, 4'hA, 3'd3}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
